// File: rtl/ysyx_24080006_pkg.sv
// Shared MDU types: decoder control bundle, iterative-unit FSM states and throughput defaults.
package ysyx_24080006_pkg;

    typedef enum logic [1:0] {
        MDU_MULL = 2'd0,
        MDU_MULH = 2'd1,
        MDU_DIV  = 2'd2,
        MDU_REM  = 2'd3
    } mdu_op_e;

    typedef struct packed {
        logic    mdu_enable;
        logic    signed_a;
        logic    signed_b;
        mdu_op_e mdu_op;
    } mdu_set_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MUL   = 3'd1,
        DIV   = 3'd2,
        FIXUP = 3'd3,
        DONE  = 3'd4
    } mdu_state_e;

    localparam int unsigned MDU_MUL_BITS = 4;
    localparam int unsigned MDU_DIV_BITS = 1;

endpackage

// File: rtl/ysyx_24080006_mdu_div_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module ysyx_24080006_mdu_div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // rem_in < divisor keeps shifted < 2*divisor, so diff's top bit is the borrow
    assign shifted = {rem_in, bit_in};
    assign diff    = shifted - {1'b0, divisor};
    assign q_bit   = ~diff[WIDTH];
    assign rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/ysyx_24080006_mdu_iter.sv
// Iterative RV32M multiply/divide unit with configurable bits per cycle,
// single-cycle divide-by-zero/overflow path, flush and back-to-back issue.
module ysyx_24080006_mdu_iter
    import ysyx_24080006_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MUL_BITS = MDU_MUL_BITS,
    parameter int unsigned DIV_BITS = MDU_DIV_BITS
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  mdu_set_t         mdu_set,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned      CNT_W      = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] MUL_CYCLES = CNT_W'(WIDTH / MUL_BITS);
    localparam logic [CNT_W-1:0] DIV_CYCLES = CNT_W'(WIDTH / DIV_BITS);
    localparam logic [WIDTH-1:0] MIN_NEG    = {1'b1, {(WIDTH-1){1'b0}}};

    mdu_state_e       state;
    mdu_op_e          op_q;
    logic             neg_a_q, neg_b_q;
    logic [WIDTH-1:0] mag_a_q, mag_b_q;
    logic [WIDTH-1:0] acc_hi_q, acc_lo_q;
    logic [WIDTH-1:0] result_q;
    logic [CNT_W-1:0] cnt_q;
    logic             out_valid_q;

    // The caller already qualifies in_valid with the enable bit
    logic unused_enable;
    assign unused_enable = mdu_set.mdu_enable;

    logic             accept, is_div, neg_a, neg_b, fast;
    logic [WIDTH-1:0] mag_a, mag_b, fast_result;

    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept   = in_valid && in_ready && !flush;

    always_comb begin
        is_div      = (mdu_set.mdu_op == MDU_DIV) || (mdu_set.mdu_op == MDU_REM);
        neg_a       = mdu_set.signed_a & op_a[WIDTH-1];
        neg_b       = (is_div ? mdu_set.signed_a : mdu_set.signed_b) & op_b[WIDTH-1];
        mag_a       = neg_a ? -op_a : op_a;
        mag_b       = neg_b ? -op_b : op_b;
        fast        = 1'b0;
        fast_result = '0;
        if (is_div && (op_b == '0)) begin
            fast        = 1'b1;
            fast_result = (mdu_set.mdu_op == MDU_DIV) ? '1 : op_a;
        end else if (is_div && mdu_set.signed_a && (op_a == MIN_NEG) && (op_b == '1)) begin
            fast        = 1'b1;
            fast_result = (mdu_set.mdu_op == MDU_DIV) ? op_a : '0;
        end
    end

    // Multiply: acc_lo holds the remaining multiplier, acc_hi the running high part
    logic [WIDTH+MUL_BITS-1:0] mul_partial, mul_sum;
    logic [WIDTH-1:0]          mul_hi_n, mul_lo_n;

    always_comb begin
        mul_partial = '0;
        for (int unsigned j = 0; j < MUL_BITS; j++) begin
            if (acc_lo_q[j]) mul_partial = mul_partial + ((WIDTH+MUL_BITS)'(mag_a_q) << j);
        end
        mul_sum  = (WIDTH+MUL_BITS)'(acc_hi_q) + mul_partial;
        mul_hi_n = mul_sum[WIDTH+MUL_BITS-1:MUL_BITS];
        mul_lo_n = {mul_sum[MUL_BITS-1:0], acc_lo_q[WIDTH-1:MUL_BITS]};
    end

    // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in
    logic [DIV_BITS-1:0] q_bits;
    logic [WIDTH-1:0]    div_rem_n, div_lo_n;

    for (genvar g = 0; g < DIV_BITS; g++) begin : g_div
        logic [WIDTH-1:0] r_in, r_out;
        logic             q;
        if (g == 0) begin : g_first
            assign r_in = acc_hi_q;
        end else begin : g_next
            assign r_in = g_div[g-1].r_out;
        end
        ysyx_24080006_mdu_div_step #(.WIDTH(WIDTH)) u_step (
            .rem_in  (r_in),
            .bit_in  (acc_lo_q[WIDTH-1-g]),
            .divisor (mag_b_q),
            .rem_out (r_out),
            .q_bit   (q)
        );
        assign q_bits[DIV_BITS-1-g] = q;
    end

    assign div_rem_n = g_div[DIV_BITS-1].r_out;
    assign div_lo_n  = {acc_lo_q[WIDTH-DIV_BITS-1:0], q_bits};

    logic [2*WIDTH-1:0] mul_full, mul_fixed;
    logic [WIDTH-1:0]   quot_fixed, rem_fixed, fixup_result;

    always_comb begin
        mul_full   = {acc_hi_q, acc_lo_q};
        mul_fixed  = (neg_a_q ^ neg_b_q) ? -mul_full : mul_full;
        quot_fixed = (neg_a_q ^ neg_b_q) ? -acc_lo_q : acc_lo_q;
        rem_fixed  = neg_a_q ? -acc_hi_q : acc_hi_q;
        fixup_result = '0;
        case (op_q)
            MDU_MULL: fixup_result = mul_fixed[WIDTH-1:0];
            MDU_MULH: fixup_result = mul_fixed[2*WIDTH-1:WIDTH];
            MDU_DIV:  fixup_result = quot_fixed;
            MDU_REM:  fixup_result = rem_fixed;
            default:  fixup_result = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            op_q        <= MDU_MULL;
            neg_a_q     <= 1'b0;
            neg_b_q     <= 1'b0;
            mag_a_q     <= '0;
            mag_b_q     <= '0;
            acc_hi_q    <= '0;
            acc_lo_q    <= '0;
            result_q    <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
        end else begin
            if (out_valid_q && out_ready) out_valid_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        op_q    <= mdu_set.mdu_op;
                        neg_a_q <= neg_a;
                        neg_b_q <= neg_b;
                        mag_a_q <= mag_a;
                        mag_b_q <= mag_b;
                        if (fast) begin
                            state       <= DONE;
                            result_q    <= fast_result;
                            out_valid_q <= 1'b1;
                        end else if (is_div) begin
                            state    <= DIV;
                            cnt_q    <= DIV_CYCLES;
                            acc_hi_q <= '0;
                            acc_lo_q <= mag_a;
                        end else begin
                            state    <= MUL;
                            cnt_q    <= MUL_CYCLES;
                            acc_hi_q <= '0;
                            acc_lo_q <= mag_b;
                        end
                    end else if ((state == DONE) && out_ready) begin
                        state <= IDLE;
                    end
                end
                MUL: begin
                    acc_hi_q <= mul_hi_n;
                    acc_lo_q <= mul_lo_n;
                    cnt_q    <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state <= FIXUP;
                end
                DIV: begin
                    acc_hi_q <= div_rem_n;
                    acc_lo_q <= div_lo_n;
                    cnt_q    <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state <= FIXUP;
                end
                FIXUP: begin
                    result_q    <= fixup_result;
                    out_valid_q <= 1'b1;
                    state       <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule

// File: tb/tb_ysyx_24080006_mdu_iter.sv
// Directed bench for the iterative MDU: three parameter variants checked against an arithmetic model.
module tb_ysyx_24080006_mdu_iter;
    import ysyx_24080006_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        out_ready = 1'b1;
    mdu_set_t    mdu_set = '0;
    logic [31:0] op_a = '0, op_b = '0;
    logic [2:0]  in_valid_v = '0;
    logic [2:0]  in_ready_v, out_valid_v;
    logic [31:0] result_v [3];
    logic [31:0] exp_v [3] = '{default: '0};
    int          n_cmp = 0, n_fail = 0;

    always #5 clock = ~clock;

    // dut0: MUL_BITS=4/DIV_BITS=1, dut1: 1/2, dut2: 8/1
    for (genvar i = 0; i < 3; i++) begin : g_dut
        ysyx_24080006_mdu_iter #(
            .WIDTH    (32),
            .MUL_BITS ((i == 0) ? 4 : ((i == 1) ? 1 : 8)),
            .DIV_BITS ((i == 1) ? 2 : 1)
        ) u_dut (
            .clock     (clock),
            .reset     (reset),
            .flush     (flush),
            .in_valid  (in_valid_v[i]),
            .in_ready  (in_ready_v[i]),
            .mdu_set   (mdu_set),
            .op_a      (op_a),
            .op_b      (op_b),
            .out_valid (out_valid_v[i]),
            .out_ready (out_ready),
            .result    (result_v[i])
        );
    end

    function automatic logic [31:0] model(mdu_op_e op, logic sa, logic sb,
                                          logic [31:0] a, logic [31:0] b);
        logic signed [64:0] ea, eb, p;
        int sq;
        ea = sa ? {{33{a[31]}}, a} : {33'b0, a};
        eb = sb ? {{33{b[31]}}, b} : {33'b0, b};
        p  = ea * eb;
        case (op)
            MDU_MULL: return p[31:0];
            MDU_MULH: return p[63:32];
            MDU_DIV: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (sa && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                if (sa) begin sq = $signed(a) / $signed(b); return sq; end
                return a / b;
            end
            default: begin
                if (b == 32'd0) return a;
                if (sa && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                if (sa) begin sq = $signed(a) % $signed(b); return sq; end
                return a % b;
            end
        endcase
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                if (out_valid_v[i] === 1'b1)
                    check($sformatf("model_dut%0d", i), result_v[i], exp_v[i]);
            end
        end
    end

    task automatic drive(mdu_op_e op, logic sa, logic sb, logic [31:0] a, logic [31:0] b);
        mdu_set = '{mdu_enable: 1'b1, signed_a: sa, signed_b: sb, mdu_op: op};
        op_a    = a;
        op_b    = b;
    endtask

    // Waits for out_valid from cycle T+1; lat is the cycle count relative to the accept edge
    task automatic wait_valid(int idx, string name, output int lat);
        lat = 1;
        while (out_valid_v[idx] !== 1'b1 && lat < 200) begin
            check($sformatf("%s busy_in_ready", name), 32'(in_ready_v[idx]), 32'd0);
            @(posedge clock); #1;
            lat++;
        end
        if (out_valid_v[idx] !== 1'b1) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s timeout: got no out_valid expected valid within 200 cycles", name);
        end
    endtask

    task automatic run_op(int idx, string name, mdu_op_e op, logic sa, logic sb,
                          logic [31:0] a, logic [31:0] b, logic [31:0] exp_res, int exp_lat);
        int lat;
        @(posedge clock); #1;
        drive(op, sa, sb, a, b);
        out_ready       = 1'b1;
        in_valid_v[idx] = 1'b1;
        check($sformatf("%s in_ready", name), 32'(in_ready_v[idx]), 32'd1);
        @(posedge clock); #1;
        in_valid_v[idx] = 1'b0;
        exp_v[idx]      = model(op, sa, sb, a, b);
        wait_valid(idx, name, lat);
        check($sformatf("%s latency", name), lat, exp_lat);
        check($sformatf("%s result", name), result_v[idx], exp_res);
        @(posedge clock); #1;
        check($sformatf("%s drop", name), 32'(out_valid_v[idx]), 32'd0);
    endtask

    initial begin
        int lat, seen;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_valid%0d", i), 32'(out_valid_v[i]), 32'd0);
            check($sformatf("rst_result%0d", i), result_v[i], 32'd0);
            check($sformatf("rst_ready%0d", i), 32'(in_ready_v[i]), 32'd1);
        end

        run_op(0, "mull_7xm3", MDU_MULL, 1, 1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 10);

        for (int i = 0; i < 3; i++) begin
            int l;
            l = (i == 0) ? 10 : ((i == 1) ? 34 : 6);
            run_op(i, $sformatf("mulhu%0d", i),  MDU_MULH, 0, 0, '1, '1, 32'hFFFF_FFFE, l);
            run_op(i, $sformatf("mulh%0d", i),   MDU_MULH, 1, 1, '1, '1, 32'h0000_0000, l);
            run_op(i, $sformatf("mulhsu%0d", i), MDU_MULH, 1, 0, '1, '1, 32'hFFFF_FFFF, l);
        end

        run_op(0, "div_m7_2",   MDU_DIV, 1, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
        run_op(0, "rem_m7_2",   MDU_REM, 1, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
        run_op(1, "div_m7_2_r2", MDU_DIV, 1, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 18);
        run_op(1, "rem_m7_2_r2", MDU_REM, 1, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 18);
        run_op(0, "divu_m7_2",  MDU_DIV, 0, 0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 34);
        run_op(0, "remu_100_7", MDU_REM, 0, 0, 32'd100, 32'd7, 32'd2, 34);

        run_op(0, "divu_5_0", MDU_DIV, 0, 0, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_op(0, "remu_5_0", MDU_REM, 0, 0, 32'd5, 32'd0, 32'd5, 1);
        run_op(0, "div_ovf",  MDU_DIV, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op(0, "rem_ovf",  MDU_REM, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

        // Backpressure then back-to-back fast-path accept
        @(posedge clock); #1;
        drive(MDU_MULL, 1, 1, 32'd7, 32'hFFFF_FFFD);
        out_ready     = 1'b0;
        in_valid_v[0] = 1'b1;
        @(posedge clock); #1;
        in_valid_v[0] = 1'b0;
        exp_v[0]      = model(MDU_MULL, 1, 1, 32'd7, 32'hFFFF_FFFD);
        wait_valid(0, "bp_mull", lat);
        check("bp_latency", lat, 10);
        repeat (5) begin
            @(posedge clock); #1;
            check("bp_hold_valid", 32'(out_valid_v[0]), 32'd1);
            check("bp_hold_result", result_v[0], 32'hFFFF_FFEB);
            check("bp_hold_ready", 32'(in_ready_v[0]), 32'd0);
        end
        drive(MDU_DIV, 0, 0, 32'd9, 32'd0);
        out_ready     = 1'b1;
        in_valid_v[0] = 1'b1;
        #1 check("b2b_in_ready", 32'(in_ready_v[0]), 32'd1);
        @(posedge clock); #1;
        in_valid_v[0] = 1'b0;
        exp_v[0]      = model(MDU_DIV, 0, 0, 32'd9, 32'd0);
        check("b2b_valid", 32'(out_valid_v[0]), 32'd1);
        check("b2b_result", result_v[0], 32'hFFFF_FFFF);
        @(posedge clock); #1;
        check("b2b_drop", 32'(out_valid_v[0]), 32'd0);

        // Flush at T+10 of a divide
        drive(MDU_DIV, 1, 1, 32'hFFFF_FFF9, 32'd2);
        in_valid_v[0] = 1'b1;
        @(posedge clock); #1;
        in_valid_v[0] = 1'b0;
        repeat (9) @(posedge clock);
        #1 flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        check("flush_ready", 32'(in_ready_v[0]), 32'd1);
        seen = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (out_valid_v[0] !== 1'b0) seen = 1;
        end
        check("flush_no_valid", seen, 0);

        // Flush beats a same-cycle accept
        drive(MDU_DIV, 0, 0, 32'd9, 32'd0);
        flush         = 1'b1;
        in_valid_v[0] = 1'b1;
        @(posedge clock); #1;
        flush         = 1'b0;
        in_valid_v[0] = 1'b0;
        check("flush_accept_valid", 32'(out_valid_v[0]), 32'd0);
        check("flush_accept_ready", 32'(in_ready_v[0]), 32'd1);

        // Reset in the middle of a multiply
        drive(MDU_MULL, 1, 1, 32'd7, 32'hFFFF_FFFD);
        in_valid_v[0] = 1'b1;
        @(posedge clock); #1;
        in_valid_v[0] = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("midrst_valid", 32'(out_valid_v[0]), 32'd0);
        check("midrst_result", result_v[0], 32'd0);
        check("midrst_ready", 32'(in_ready_v[0]), 32'd1);
        seen = 0;
        repeat (15) begin
            @(posedge clock); #1;
            if (out_valid_v[0] !== 1'b0) seen = 1;
        end
        check("midrst_no_valid", seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected finish before 200000");
        $fatal(1);
    end

endmodule
